// File: rtl/nand_page_ctrl_if.sv
// Host-side and flash-pin bundle for the NAND page controller.
// Latency: none; plain wires grouped for port connection.
// Backpressure: cmd_valid/cmd_ready for commands, rd_valid/rd_ready for page bytes.
interface nand_page_ctrl_if;
   // host command side
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr;
   // page data stream and completion
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        done;
   logic [7:0]  status;
   logic        error;
   // flash pins
   logic        CE_n;
   logic        CLE;
   logic        ALE;
   logic        WE_n;
   logic        RE_n;
   logic        WP_n;
   logic [7:0]  io_out;
   logic [7:0]  io_in;
   logic        FDataOE;
   logic        RB;

   // controller view
   modport master (
      input  cmd_valid, cmd_op, cmd_addr, rd_ready, io_in, RB,
      output cmd_ready, rd_data, rd_valid, done, status, error,
      output CE_n, CLE, ALE, WE_n, RE_n, WP_n, io_out, FDataOE
   );

   // host + flash environment view
   modport slave (
      output cmd_valid, cmd_op, cmd_addr, rd_ready, io_in, RB,
      input  cmd_ready, rd_data, rd_valid, done, status, error,
      input  CE_n, CLE, ALE, WE_n, RE_n, WP_n, io_out, FDataOE
   );
endinterface

// File: rtl/nand_page_ctrl.sv
// NAND flash initiator: device reset (FFh), page read (00h/addr x4/30h + data), block erase (60h/row x2/D0h + 70h status).
// Latency: op accepted in IDLE, CMD bus cycle starts next clock; done is a one-cycle pulse, cmd_ready back the cycle after.
// Backpressure: one op in flight (cmd_ready only in IDLE); page bytes held on rd_valid until rd_ready, next RE_n fall waits for it.
// Optional busy timeout in WAIT_RB is compiled in with NAND_BUSY_TIMEOUT_EN.
module nand_page_ctrl #(
   parameter int PAGE_BYTES = 2112,
   parameter int WE_LO_CYC  = 2,
   parameter int WE_HI_CYC  = 2,
   parameter int TWB_CYC    = 10,
   parameter int TWHR_CYC   = 6
`ifdef NAND_BUSY_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 400000
`endif
) (
   input  logic             clk,
   input  logic             rst,
   nand_page_ctrl_if.master bus
);

   localparam logic [1:0]  OP_RESET  = 2'b00;
   localparam logic [1:0]  OP_READ   = 2'b01;
   localparam logic [1:0]  OP_ERASE  = 2'b10;
   localparam logic [1:0]  OP_ILL    = 2'b11;

   localparam logic [15:0] LO_LEN    = 16'(WE_LO_CYC);
   localparam logic [15:0] LO_LAST   = 16'(WE_LO_CYC - 1);
   localparam logic [15:0] HI_LAST   = 16'(WE_HI_CYC - 1);
   localparam logic [15:0] WR_LAST   = 16'(WE_LO_CYC + WE_HI_CYC - 1);
   localparam logic [15:0] TWB_LAST  = 16'(TWB_CYC - 1);
   localparam logic [15:0] TWHR_LAST = 16'(TWHR_CYC - 1);
   localparam logic [11:0] BYTE_LAST = 12'(PAGE_BYTES - 1);
`ifdef NAND_BUSY_TIMEOUT_EN
   localparam logic [18:0] TMO_LAST  = 19'(TIMEOUT_CYC - 1);
`endif

   typedef enum logic [3:0] {
      IDLE,
      CMD,
      ADDR,
      CONF,
      WAIT_WB,
      WAIT_RB,
      READ_LO,
      READ_HI,
      STAT_CMD,
      STAT_WAIT,
      STAT_RD,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;          // bus-cycle phase / wait counter
   logic [1:0]  idx_q, idx_d;          // address cycle index
   logic [11:0] byte_q, byte_d;        // page byte counter
   logic [1:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic [7:0]  status_q, status_d;
   logic        err_q, err_d;
   logic        rb_meta_q, rb_meta_d;
   logic        rb_sync_q, rb_sync_d;
`ifdef NAND_BUSY_TIMEOUT_EN
   logic [18:0] tmo_q, tmo_d;
`endif

   logic        rd_hs;
   logic [1:0]  addr_last;
   logic        legal;
   logic        busy_op;
   logic        wr_state;
   logic [1:0]  sel;
   logic [7:0]  wr_byte;

   // Register update; rst drops straight back to IDLE without touching the flash.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         byte_q     <= '0;
         op_q       <= OP_RESET;
         addr_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         status_q   <= '0;
         err_q      <= 1'b0;
         rb_meta_q  <= 1'b0;
         rb_sync_q  <= 1'b0;
`ifdef NAND_BUSY_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         byte_q     <= byte_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         status_q   <= status_d;
         err_q      <= err_d;
         rb_meta_q  <= rb_meta_d;
         rb_sync_q  <= rb_sync_d;
`ifdef NAND_BUSY_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   // Sequencer: next state, phase counters, byte capture and RB synchronizer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      idx_d      = idx_q;
      byte_d     = byte_q;
      op_d       = op_q;
      addr_d     = addr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      status_d   = status_q;
      err_d      = err_q;
      rb_meta_d  = bus.RB;
      rb_sync_d  = rb_meta_q;
`ifdef NAND_BUSY_TIMEOUT_EN
      tmo_d      = '0;
`endif
      rd_hs      = rd_valid_q && bus.rd_ready;
      addr_last  = (op_q == OP_READ) ? 2'd3 : 2'd1;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               addr_d  = bus.cmd_addr;
               err_d   = 1'b0;
               idx_d   = '0;
               byte_d  = '0;
               state_d = CMD;
            end
         end
         CMD: begin
            if (op_q == OP_ILL) begin
               // no bus activity for an illegal op, just report it
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end else if (cnt_q == WR_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = (op_q == OP_RESET) ? WAIT_WB : ADDR;
            end
         end
         ADDR: begin
            if (cnt_q == WR_LAST) begin
               cnt_d = '0;
               if (idx_q == addr_last) begin
                  state_d = CONF;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         CONF: begin
            if (cnt_q == WR_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_WB;
            end
         end
         WAIT_WB: begin
            // RB is not trusted until the flash has had tWB to pull it low
            if (cnt_q == TWB_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_RB;
            end
         end
         WAIT_RB: begin
            cnt_d = '0;
`ifdef NAND_BUSY_TIMEOUT_EN
            tmo_d = tmo_q + 19'd1;
`endif
            if (rb_sync_q) begin
               case (op_q)
                  OP_READ:  state_d = READ_LO;
                  OP_ERASE: state_d = STAT_CMD;
                  default:  state_d = DONE;
               endcase
            end
`ifdef NAND_BUSY_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
`endif
         end
         READ_LO: begin
            // sample io on the last low cycle, just before RE_n rises
            if (cnt_q == LO_LAST) begin
               rd_data_d  = bus.io_in;
               rd_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = READ_HI;
            end
         end
         READ_HI: begin
            cnt_d = (cnt_q < HI_LAST) ? cnt_q + 16'd1 : cnt_q;
            if (rd_hs) begin
               rd_valid_d = 1'b0;
               byte_d     = byte_q + 12'd1;
            end
            if (rd_hs && (byte_q == BYTE_LAST)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else if ((cnt_q >= HI_LAST) && (rd_hs || !rd_valid_q)) begin
               // next RE_n fall only once the held byte has gone
               cnt_d   = '0;
               state_d = READ_LO;
            end
         end
         STAT_CMD: begin
            if (cnt_q == WR_LAST) begin
               cnt_d   = '0;
               state_d = STAT_WAIT;
            end
         end
         STAT_WAIT: begin
            // counted after the 70h high phase, so the gap is at least tWHR
            if (cnt_q == TWHR_LAST) begin
               cnt_d   = '0;
               state_d = STAT_RD;
            end
         end
         STAT_RD: begin
            if (cnt_q == LO_LAST) begin
               status_d = bus.io_in;
               err_d    = bus.io_in[0];
               cnt_d    = '0;
               state_d  = DONE;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Pin and host-side output decode from the registered state.
   always_comb begin
      legal    = (op_q != OP_ILL);
      busy_op  = legal && (state_q != IDLE) && (state_q != DONE);
      wr_state = (state_q == CMD) || (state_q == ADDR) ||
                 (state_q == CONF) || (state_q == STAT_CMD);
      // erase only sends the row bytes 2 and 3
      sel      = (op_q == OP_ERASE) ? (idx_q + 2'd2) : idx_q;
      wr_byte  = 8'h00;
      case (state_q)
         CMD: begin
            case (op_q)
               OP_RESET: wr_byte = 8'hFF;
               OP_ERASE: wr_byte = 8'h60;
               default:  wr_byte = 8'h00;
            endcase
         end
         ADDR:     wr_byte = addr_q[{sel, 3'b000} +: 8];
         CONF:     wr_byte = (op_q == OP_READ) ? 8'h30 : 8'hD0;
         STAT_CMD: wr_byte = 8'h70;
         default:  wr_byte = 8'h00;
      endcase

      bus.CE_n    = !busy_op;
      bus.WP_n    = busy_op && (op_q == OP_ERASE);
      bus.WE_n    = 1'b1;
      bus.CLE     = 1'b0;
      bus.ALE     = 1'b0;
      bus.io_out  = 8'h00;
      bus.FDataOE = 1'b0;
      bus.RE_n    = !(busy_op && ((state_q == READ_LO) || (state_q == STAT_RD)));
      if (busy_op && wr_state) begin
         // latch values are presented with the WE_n fall and held through the high phase
         bus.WE_n    = (cnt_q >= LO_LEN);
         bus.CLE     = (state_q != ADDR);
         bus.ALE     = (state_q == ADDR);
         bus.io_out  = wr_byte;
         bus.FDataOE = 1'b1;
      end

      bus.cmd_ready = (state_q == IDLE);
      bus.done      = (state_q == DONE);
      bus.error     = (state_q == DONE) && err_q;
      bus.rd_valid  = rd_valid_q;
      bus.rd_data   = rd_data_q;
      bus.status    = status_q;
   end

endmodule

// File: tb/tb_nand_page_ctrl.sv
// Bench for nand_page_ctrl: behavioural flash model, random page data and busy times, directed op sequence.
// Latency: checks done timing against bus-cycle arithmetic; sink drives rd_ready in several patterns.
// Backpressure: watches that RE_n never falls while a byte is held unaccepted.
module tb_nand_page_ctrl;
   localparam int PAGE   = 2112;
   localparam int WR_CYC = 4;   // WE_LO_CYC + WE_HI_CYC
   localparam int TWB    = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nand_page_ctrl_if bus ();

   nand_page_ctrl #(
      .PAGE_BYTES(PAGE)
`ifdef NAND_BUSY_TIMEOUT_EN
      , .TIMEOUT_CYC(50)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // flash model state
   logic [7:0]  page_mem [PAGE];
   logic [11:0] wlog [$];        // {FDataOE, WP_n, CLE, ALE, io} at each WE_n rise
   logic [11:0] exq [$];
   int   col = 0;
   logic stat_mode = 1'b0;
   logic [7:0] stat_byte = 8'h00;
   int   busy_cyc = 50;
   int   rb_rise_cyc = 0;
   int   we_edges = 0;
   int   re_edges = 0;
   event busy_ev;

   // sink / monitor state
   int   rdy_mode = 0;
   int   rcv = 0;
   int   re_viol = 0;
   int   ce_low = 0;
   logic re_prev = 1'b1;
   logic blocked_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // flash: latch command/address bytes on WE_n rise
   initial forever begin
      @(posedge bus.WE_n);
      #1;
      we_edges++;
      if (bus.CE_n === 1'b0) begin
         wlog.push_back({bus.FDataOE, bus.WP_n, bus.CLE, bus.ALE, bus.io_out});
         if (bus.CLE) begin
            case (bus.io_out)
               8'h00:               begin col = 0; stat_mode = 1'b0; end
               8'h30, 8'hFF, 8'hD0: begin stat_mode = 1'b0; ->busy_ev; end
               8'h70:               stat_mode = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // flash: present data after RE_n falls
   initial forever begin
      @(negedge bus.RE_n);
      re_edges++;
      #1;
      if (stat_mode) begin
         bus.io_in = stat_byte;
      end else begin
         bus.io_in = page_mem[col % PAGE];
         col++;
      end
   end

   // flash: RB goes busy a little after the confirm (with a glitch inside tWB), then ready
   initial forever begin
      @(busy_ev);
      repeat (2) @(posedge clk);
      #1 bus.RB = 1'b0;
      @(posedge clk);
      #1 bus.RB = 1'b1;
      @(posedge clk);
      #1 bus.RB = 1'b0;
      repeat (busy_cyc) @(posedge clk);
      #1 bus.RB = 1'b1;
      rb_rise_cyc = cyc;
   end

   // sink ready pattern
   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       bus.rd_ready = 1'b1;
         1:       bus.rd_ready = 1'($urandom);
         default: bus.rd_ready = ((cyc % 3) == 0);
      endcase
   end

   // sink: byte scoreboard, RE_n rule and CE_n activity
   initial forever begin
      @(negedge clk);
      if (bus.RE_n === 1'b0 && re_prev && blocked_prev) re_viol++;
      re_prev      = bus.RE_n;
      blocked_prev = bus.rd_valid && !bus.rd_ready;
      if (bus.CE_n === 1'b0) ce_low++;
      if (!rst && bus.rd_valid && bus.rd_ready) begin
         if (rcv < PAGE) chk("rd_data", {24'd0, bus.rd_data}, {24'd0, page_mem[rcv]});
         rcv++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   task automatic check_idle(input string tag);
      chk({tag, "_pins"},
          {21'd0, bus.CE_n, bus.WE_n, bus.RE_n, bus.CLE, bus.ALE, bus.WP_n,
           bus.FDataOE, bus.rd_valid, bus.done, bus.error, bus.cmd_ready},
          32'b111_0000_0001);
      chk({tag, "_io"}, {24'd0, bus.io_out}, 32'h0);
      chk({tag, "_status"}, {24'd0, bus.status}, 32'h0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] addr, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = addr;
      while (!bus.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept", {31'd0, bus.cmd_ready}, 32'd1);
      acc = cyc;
      wlog.delete();
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_addr  = $urandom;
      chk("rdy_drop", {31'd0, bus.cmd_ready}, 32'd0);
   endtask

   task automatic wait_done(input int budget, output int dcyc, output logic err);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", {31'd0, bus.done}, 32'd1);
      dcyc = cyc;
      err  = bus.error;
      @(negedge clk);
      chk("done_pulse", {30'd0, bus.done, bus.cmd_ready}, 32'b01);
   endtask

   task automatic build_exp(input logic [1:0] op, input logic [31:0] a);
      logic wp;
      wp = (op == 2'b10);
      exq.delete();
      case (op)
         2'b00: exq.push_back({1'b1, wp, 2'b10, 8'hFF});
         2'b01: begin
            exq.push_back({1'b1, wp, 2'b10, 8'h00});
            for (int i = 0; i < 4; i++) exq.push_back({1'b1, wp, 2'b01, a[8*i +: 8]});
            exq.push_back({1'b1, wp, 2'b10, 8'h30});
         end
         2'b10: begin
            exq.push_back({1'b1, wp, 2'b10, 8'h60});
            exq.push_back({1'b1, wp, 2'b01, a[23:16]});
            exq.push_back({1'b1, wp, 2'b01, a[31:24]});
            exq.push_back({1'b1, wp, 2'b10, 8'hD0});
            exq.push_back({1'b1, wp, 2'b10, 8'h70});
         end
         default: ;
      endcase
   endtask

   task automatic cmp_wlog(input string tag);
      chk({tag, "_wcount"}, wlog.size(), exq.size());
      for (int i = 0; i < exq.size() && i < wlog.size(); i++)
         chk({tag, "_wbyte"}, {20'd0, wlog[i]}, {20'd0, exq[i]});
   endtask

   task automatic page_read(input string tag, input logic [31:0] a, input int mode);
      int acc, dcyc;
      logic err;
      foreach (page_mem[i]) page_mem[i] = 8'($urandom);
      rdy_mode = mode;
      busy_cyc = 150 + int'($urandom_range(0, 200));
      rcv = 0;
      re_viol = 0;
      build_exp(2'b01, a);
      issue(2'b01, a, acc);
      wait_done(40000, dcyc, err);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_count"}, rcv, PAGE);
      chk({tag, "_re_falls"}, col, PAGE);
      chk({tag, "_re_rule"}, re_viol, 0);
      cmp_wlog(tag);
   endtask

   task automatic erase(input string tag, input logic [31:0] a, input logic [7:0] sb);
      int acc, dcyc;
      logic err;
      stat_byte = sb;
      busy_cyc  = 300 + int'($urandom_range(0, 300));
      build_exp(2'b10, a);
      issue(2'b10, a, acc);
      wait_done(5000, dcyc, err);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, sb[0]});
      chk({tag, "_status"}, {24'd0, bus.status}, {24'd0, sb});
      chk({tag, "_busy_wait"}, {31'd0, (dcyc > rb_rise_cyc)}, 32'd1);
      cmp_wlog(tag);
   endtask

   initial begin
      int acc, dcyc, n, we0, re0;
      logic err;
      logic [31:0] ra;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = 32'h0;
      bus.io_in     = 8'h00;
      bus.RB        = 1'b1;
      bus.rd_ready  = 1'b1;
      foreach (page_mem[i]) page_mem[i] = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;

      // device reset op
      busy_cyc = 80 + int'($urandom_range(0, 40));
      build_exp(2'b00, $urandom);
      issue(2'b00, $urandom, acc);
      wait_done(2000, dcyc, err);
      chk("rstop_err", {31'd0, err}, 32'd0);
      chk("rstop_latency", {31'd0, ((dcyc - rb_rise_cyc) >= 2 && (dcyc - rb_rise_cyc) <= 6)}, 32'd1);
      cmp_wlog("rstop");

      // page reads: fixed address with random ready, random address with 1-of-3 ready
      page_read("read_a", 32'h0403_0201, 1);
      ra = $urandom;
      page_read("read_b", ra, 2);

      // erases: clean status, then a failing status
      erase("erase_a", 32'hBBAA_0000, 8'h00);
      erase("erase_b", $urandom, 8'($urandom) | 8'h01);

      // illegal op
      ce_low = 0;
      issue(2'b11, $urandom, acc);
      wait_done(20, dcyc, err);
      chk("ill_latency", dcyc - acc, 2);
      chk("ill_err", {31'd0, err}, 32'd1);
      chk("ill_ce", ce_low, 0);
      chk("ill_wcount", wlog.size(), 0);

      // rst held mid read-data phase
      foreach (page_mem[i]) page_mem[i] = 8'($urandom);
      rdy_mode = 0;
      busy_cyc = 100;
      rcv = 0;
      issue(2'b01, $urandom, acc);
      n = 0;
      while (rcv < 100 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_reached", {31'd0, (rcv >= 100)}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_idle("mid_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      we0 = we_edges;
      re0 = re_edges;
      repeat (50) @(negedge clk);
      chk("mid_we_quiet", we_edges - we0, 0);
      chk("mid_re_quiet", re_edges - re0, 0);
      check_idle("mid_after");

`ifdef NAND_BUSY_TIMEOUT_EN
      // busy timeout with RB held low
      busy_cyc = 300;
      issue(2'b00, 32'h0, acc);
      wait_done(500, dcyc, err);
      chk("tmo_latency", dcyc - acc, 1 + WR_CYC + TWB + 50);
      chk("tmo_err", {31'd0, err}, 32'd1);
      n = 0;
      while (bus.RB !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
